// File: rtl/fetch_1_pkg.sv
// Shared parameter header for the fetch stage: memory geometry, queue defaults, entry payload.
package fetch_1_pkg;

    localparam int unsigned MEMI_SIZE_LOG    = 4;
    localparam int unsigned MEMI_SIZE        = 1 << MEMI_SIZE_LOG;
    localparam int unsigned INST_LEN         = 32;
    localparam int unsigned FQ_DEPTH_DEF     = 4;
    localparam int unsigned FQ_DEPTH_LOG_DEF = 2;

    typedef struct packed {
        logic [MEMI_SIZE_LOG-1:0] pc;
        logic [INST_LEN-1:0]      inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: push at tail, pop at head, flush empties; occupancy drives full/empty.
module fetch_queue
    import fetch_1_pkg::*;
#(
    parameter int unsigned DEPTH     = FQ_DEPTH_DEF,
    parameter int unsigned DEPTH_LOG = FQ_DEPTH_LOG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fq_entry_t        wdata,
    output fq_entry_t        rdata,
    output logic [DEPTH_LOG:0] count
);

    logic [DEPTH_LOG-1:0] head;
    logic [DEPTH_LOG-1:0] tail;
    fq_entry_t            mem [DEPTH];

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + DEPTH_LOG'(1);
            if (pop)  head <= head + DEPTH_LOG'(1);
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_LOG+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage needs no reset; contents are ignored while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= wdata;
    end

    assign rdata = mem[head];

endmodule

// File: rtl/fetch_1.sv
// Instruction fetch: PC register feeding a same-cycle memory, buffered through fetch_queue.
module fetch_1
    import fetch_1_pkg::*;
#(
    parameter int unsigned FQ_DEPTH     = FQ_DEPTH_DEF,
    parameter int unsigned FQ_DEPTH_LOG = FQ_DEPTH_LOG_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [MEMI_SIZE_LOG-1:0] req_addr,
    input  logic [INST_LEN-1:0]      resp_data,
    input  logic                     redirect_valid,
    input  logic [MEMI_SIZE_LOG-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_LEN-1:0]      out_inst,
    output logic [MEMI_SIZE_LOG-1:0] out_pc,
    output logic [FQ_DEPTH_LOG:0]    fq_count
);

    logic [MEMI_SIZE_LOG-1:0] pc;
    logic                     push;
    logic                     pop;
    fq_entry_t                wr_entry;
    fq_entry_t                head_entry;

    // Redirect blocks both queue ports; a pop frees a slot so a full queue still fetches.
    always_comb begin
        pop      = out_valid && out_ready && !redirect_valid;
        push     = !redirect_valid &&
                   ((fq_count < (FQ_DEPTH_LOG+1)'(FQ_DEPTH)) || pop);
        wr_entry = '{pc: pc, inst: resp_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + MEMI_SIZE_LOG'(1);
        end
    end

    fetch_queue #(
        .DEPTH     (FQ_DEPTH),
        .DEPTH_LOG (FQ_DEPTH_LOG)
    ) u_fetch_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head_entry),
        .count (fq_count)
    );

    assign req_addr  = pc;
    assign out_valid = (fq_count != '0);
    assign out_inst  = head_entry.inst;
    assign out_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_1.sv
// Bench for fetch_1: directed vector table plus randomized traffic against a queue-based model.
module tb_fetch_1;
    import fetch_1_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [MEMI_SIZE_LOG-1:0] req_addr;
    logic [INST_LEN-1:0]      resp_data;
    logic                     redirect_valid = 1'b0;
    logic [MEMI_SIZE_LOG-1:0] redirect_pc = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [INST_LEN-1:0]      out_inst;
    logic [MEMI_SIZE_LOG-1:0] out_pc;
    logic [FQ_DEPTH_LOG_DEF:0] fq_count;

    fetch_1 dut (
        .clk            (clk),
        .rst            (rst),
        .req_addr       (req_addr),
        .resp_data      (resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    logic [INST_LEN-1:0] tb_mem [MEMI_SIZE];
    assign resp_data = tb_mem[req_addr];

    typedef struct {
        int unsigned pc;
        logic [INST_LEN-1:0] inst;
    } ent_t;

    ent_t        mq[$];
    int unsigned mpc;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        bit          rst;
        bit          rd;
        int unsigned rpc;
        bit          rdy;
        int unsigned cnt;
        bit          vld;
        int unsigned opc;
        int unsigned addr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, "_count"}, 64'(fq_count), 64'(mq.size()));
        check({tag, "_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check({tag, "_addr"},  64'(req_addr), 64'(mpc));
        if (mq.size() != 0) begin
            check({tag, "_out_pc"},   64'(out_pc),   64'(mq[0].pc));
            check({tag, "_out_inst"}, 64'(out_inst), 64'(mq[0].inst));
        end
    endtask

    // One clock: drive inputs, advance the model by the fetch rules, compare after the edge.
    task automatic cycle(input bit rd, input int unsigned rpc, input bit rdy, input string tag);
        bit p_pop;
        bit p_push;
        redirect_valid = rd;
        redirect_pc    = MEMI_SIZE_LOG'(rpc);
        out_ready      = rdy;
        if (rd) begin
            mq.delete();
            mpc = rpc % MEMI_SIZE;
        end else begin
            p_pop  = (mq.size() != 0) && rdy;
            p_push = (mq.size() < FQ_DEPTH_DEF) || p_pop;
            if (p_pop) void'(mq.pop_front());
            if (p_push) begin
                mq.push_back('{pc: mpc, inst: tb_mem[mpc]});
                mpc = (mpc + 1) % MEMI_SIZE;
            end
        end
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    // Reset pulse between edges; state must clear before the next edge.
    task automatic do_reset();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_count", 64'(fq_count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_addr",  64'(req_addr), 64'd0);
        mq.delete();
        mpc = 0;
        #1;
        rst = 1'b0;
    endtask

    function automatic vec_t mk(bit r, bit rd, int unsigned rpc, bit rdy,
                                int unsigned cnt, bit vld, int unsigned opc, int unsigned addr);
        vec_t v;
        v.rst = r; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.cnt = cnt; v.vld = vld; v.opc = opc; v.addr = addr;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < int'(MEMI_SIZE); i++) tb_mem[i] = $urandom;

        // Streaming with consumer always ready.
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2, 3));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3, 4));
        // Stall until full, then one pop while full.
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 4, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 4, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 4, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 1, 4, 1, 1, 5));
        vecs.push_back(mk(0, 0, 0, 1, 4, 1, 2, 6));
        // Redirect with three queued and ready high.
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 3));
        vecs.push_back(mk(0, 1, 6, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 6, 7));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 7, 8));
        // Back-to-back redirects, then PC wrap at the top of memory.
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 14, 1, 0, 0, 0, 14));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 14, 15));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 14, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 15, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0, 2));
        // Two queued, then a mid-cycle reset pulse.
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 2));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (vecs[i].rst) do_reset();
            cycle(vecs[i].rd, vecs[i].rpc, vecs[i].rdy, tag);
            check({tag, "_tcount"}, 64'(fq_count), 64'(vecs[i].cnt));
            check({tag, "_tvalid"}, 64'(out_valid), 64'(vecs[i].vld));
            check({tag, "_taddr"},  64'(req_addr), 64'(vecs[i].addr));
            if (vecs[i].vld) check({tag, "_topc"}, 64'(out_pc), 64'(vecs[i].opc));
        end

        // Randomized traffic: redirects, backpressure and occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, MEMI_SIZE - 1),
                  $urandom_range(0, 2) != 0, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_1.md
FETCH_1 -- requirements
Module: fetch_1

Interface
REQ-001 SHALL take parameter FQ_DEPTH, default 4, fetch-queue entry count (power of two, >=2).
REQ-002 SHALL take parameter FQ_DEPTH_LOG, default 2, log2(FQ_DEPTH).
REQ-003 SHALL provide: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide: req_addr  output  MEMI_SIZE_LOG  instruction-memory read address (= PC).
REQ-006 SHALL provide: resp_data  input  INST_LEN  instruction word, combinational same-cycle response to req_addr.
REQ-007 SHALL provide: redirect_valid  input  1  flush queue and restart fetch.
REQ-008 SHALL provide: redirect_pc  input  MEMI_SIZE_LOG  restart address.
REQ-009 SHALL provide: out_valid  output  1  queue head holds an instruction.
REQ-010 SHALL provide: out_ready  input  1  consumer accepts head this cycle.
REQ-011 SHALL provide: out_inst  output  INST_LEN  head instruction word.
REQ-012 SHALL provide: out_pc  output  MEMI_SIZE_LOG  head instruction address.
REQ-013 SHALL provide: fq_count  output  FQ_DEPTH_LOG+1  current occupancy.

Function
REQ-014 SHALL drive req_addr = pc register at all times (combinational from state).
REQ-015 SHALL define push = !redirect_valid && (fq_count<FQ_DEPTH || pop); pop = out_valid && out_ready && !redirect_valid.
REQ-016 On push SHALL write {pc, resp_data} at tail and set pc <= pc+1 modulo 2^MEMI_SIZE_LOG (MEMI_SIZE-1 wraps to 0).
REQ-017 When not pushing and not redirecting SHALL hold pc.
REQ-018 Full with pop SHALL push and pop in same cycle; fq_count unchanged.
REQ-019 Empty: out_valid=0; out_ready ignored; a pushed entry SHALL appear at out_valid next cycle (1-cycle latency, no bypass).
REQ-020 out_valid SHALL equal (fq_count!=0); out_inst/out_pc SHALL be head entry, stable while out_valid && !out_ready.
REQ-021 redirect_valid SHALL have priority: next cycle fq_count=0, out_valid=0, pc=redirect_pc; no push or pop that cycle.
REQ-022 Redirect on consecutive cycles SHALL each take effect; last redirect_pc wins.
REQ-023 Head/tail pointers SHALL be FQ_DEPTH_LOG bits, wrapping naturally; full/empty from fq_count only.
REQ-024 fq_count SHALL never exceed FQ_DEPTH nor underflow.

Reset
REQ-025 rst asserted SHALL immediately set pc=0, head=tail=0, fq_count=0, out_valid=0, independent of clk.
REQ-026 Queue data storage SHALL not require reset; out_inst/out_pc are don't-care while out_valid=0.
REQ-027 Reset mid-operation SHALL discard all queued entries; first fetch after deassertion from address 0.
REQ-028 First push SHALL occur on first rising edge with rst low.

Structure
REQ-029 FQ_DEPTH and FQ_DEPTH_LOG defaults SHALL live in the shared parameter header beside MEMI_SIZE_LOG and INST_LEN.
REQ-030 Queue storage and pointers SHALL be sub-module fetch_queue (push/pop/flush, data width INST_LEN+MEMI_SIZE_LOG); PC and control in fetch_1.
REQ-031 No combinational path from out_ready to req_addr other than through push enable into pc register.

Verification
REQ-032 Reset, memory zero-initialised, out_ready=1 -> out_pc 0,1,2,... one per cycle from cycle 2, out_valid held 1.
REQ-033 out_ready=0 for 6 cycles, FQ_DEPTH=4 -> fq_count 1,2,3,4,4,4; pc stops at 4; out_pc stays 0.
REQ-034 Full queue, out_ready=1 one cycle -> pc 4->5, fq_count stays 4, next head out_pc=1.
REQ-035 redirect_valid with redirect_pc=6 and out_ready=1 while 3 entries queued -> next cycle out_valid=0, fq_count=0, req_addr=6; following cycle out_pc=6.
REQ-036 pc at MEMI_SIZE-1, push -> pc=0; out_pc sequence MEMI_SIZE-1 then 0.
REQ-037 rst pulse between clock edges with 2 entries queued -> fq_count=0, out_valid=0, req_addr=0 before next edge.
